// File: rtl/rx_os_pkg.sv
// Shared types and field layout for the receive ordered-set qualification engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_os_pkg;

   // Run-control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_TOUT = 2'd3
   } state_e;

   // Per-lane OS summary layout; bits above UPCFG_BIT carry nothing of interest
   localparam int LINK_LSB  = 0;
   localparam int RATE_LSB  = 8;
   localparam int TS1_BIT   = 16;
   localparam int TS2_BIT   = 17;
   localparam int UPCFG_BIT = 18;

   // Link number a lane reports before link numbers are assigned
   localparam logic [7:0] PAD_LINK = 8'hF7;

endpackage

// File: rtl/rx_os_lane_counter.sv
// One lane: checks each OS against the run config and counts consecutive identical matches.
// Latency: counter updates on the osValid beat edge; qualified flag one cycle later.
// Backpressure: none; every valid beat is consumed, counts freeze while not running.
module rx_os_lane_counter
   import rx_os_pkg::*;
#(
   parameter int CNT_W = 5,
   parameter int SUM_W = 24
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_run,
   input  logic             i_clr,
   input  logic             i_active,
   input  logic             i_vld,
   input  logic [SUM_W-1:0] i_sum,
   input  logic             i_exp_ts2,
   input  logic             i_pad_ok,
   input  logic [7:0]       i_link,
   input  logic [CNT_W-1:0] i_target,
   output logic             o_qual,
   output logic [7:0]       o_rate,
   output logic             o_upcfg
);

   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_rate;
   logic             r_upcfg;
   logic             r_qual;

   logic [7:0] w_link;
   logic [7:0] w_rate;
   logic       w_upcfg;
   logic       w_type_ok;
   logic       w_link_ok;
   logic       w_match;
   logic       w_same;

   assign w_link    = i_sum[LINK_LSB +: 8];
   assign w_rate    = i_sum[RATE_LSB +: 8];
   assign w_upcfg   = i_sum[UPCFG_BIT];
   assign w_type_ok = i_exp_ts2 ? i_sum[TS2_BIT] : i_sum[TS1_BIT];
   assign w_link_ok = (w_link == i_link) || (i_pad_ok && (w_link == PAD_LINK));
   assign w_match   = w_type_ok && w_link_ok;
   // A match only extends the run if its content matches what the run started with
   assign w_same    = (w_rate == r_rate) && (w_upcfg == r_upcfg);

   // Consecutive-match counter, content store and registered qualified flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_rate  <= '0;
         r_upcfg <= 1'b0;
         r_qual  <= 1'b0;
      end else if (i_clr) begin
         r_cnt   <= '0;
         r_rate  <= '0;
         r_upcfg <= 1'b0;
         r_qual  <= 1'b0;
      end else if (i_run) begin
         if (!i_active) begin
            r_cnt <= '0;
         end else if (i_vld) begin
            if (w_match) begin
               if (w_same) begin
                  if (r_cnt != {CNT_W{1'b1}}) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_cnt   <= CNT_W'(1);
                  r_rate  <= w_rate;
                  r_upcfg <= w_upcfg;
               end
            end else begin
               r_cnt <= '0;
            end
         end
         r_qual <= i_active && (r_cnt >= i_target);
      end
   end

   assign o_qual  = r_qual;
   assign o_rate  = r_rate;
   assign o_upcfg = r_upcfg;

endmodule

// File: rtl/rx_os_consensus.sv
// Per-lane TS1/TS2 qualification with run control: declares done when the required lanes qualify, else times out.
// Latency: 2 cycles from the beat completing the target count to done.
// Backpressure: none; osValid beats are consumed every cycle, results are held levels.
module rx_os_consensus
   import rx_os_pkg::*;
#(
   parameter int NUM_LANES = 16,
   parameter int CNT_W     = 5,
   parameter int TMR_W     = 24,
   parameter int SUM_W     = 24
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [NUM_LANES*SUM_W-1:0] osSummary,
   input  logic [NUM_LANES-1:0]       osValid,
   input  logic [NUM_LANES-1:0]       activeLanes,
   input  logic                       expectTs2,
   input  logic                       anyLaneMode,
   input  logic                       padAllowed,
   input  logic [7:0]                 expLinkNum,
   input  logic [CNT_W-1:0]           target,
   input  logic [TMR_W-1:0]           timeoutCycles,
   output logic                       busy,
   output logic                       done,
   output logic                       timedOut,
   output logic [NUM_LANES-1:0]       laneQualified,
   output logic [7:0]                 rateId,
   output logic                       upConfig
);

   state_e r_state;
   state_e w_state_nxt;

   // Run configuration captured at start
   logic [NUM_LANES-1:0] r_active;
   logic                 r_exp_ts2;
   logic                 r_any;
   logic                 r_pad;
   logic [7:0]           r_link;
   logic [CNT_W-1:0]     r_target;
   logic [TMR_W-1:0]     r_timeout;

   logic [TMR_W-1:0]     r_tmr;
   logic [7:0]           r_rate;
   logic                 r_upcfg;

   logic                 w_clr;
   logic                 w_run;
   logic                 w_success;
   logic                 w_expire;
   logic                 w_load;
   logic [7:0]           w_lane_rate [NUM_LANES];
   logic [NUM_LANES-1:0] w_lane_up;
   logic [7:0]           w_sel_rate;
   logic                 w_sel_up;

   assign w_clr = start | abort;
   assign w_run = (r_state == ST_RUN);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      rx_os_lane_counter #(
         .CNT_W (CNT_W),
         .SUM_W (SUM_W)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .i_run     (w_run),
         .i_clr     (w_clr),
         .i_active  (r_active[g]),
         .i_vld     (osValid[g]),
         .i_sum     (osSummary[g*SUM_W +: SUM_W]),
         .i_exp_ts2 (r_exp_ts2),
         .i_pad_ok  (r_pad),
         .i_link    (r_link),
         .i_target  (r_target),
         .o_qual    (laneQualified[g]),
         .o_rate    (w_lane_rate[g]),
         .o_upcfg   (w_lane_up[g])
      );
   end

   // laneQualified is already masked by the active set, so all-mode is a straight compare
   assign w_success = r_any ? (|laneQualified)
                            : ((|r_active) && (laneQualified == r_active));
   assign w_expire  = (r_timeout != '0) && (r_tmr == (r_timeout - TMR_W'(1)));

   // Lowest-index qualified lane supplies the reported rate id / upconfigure bit
   always_comb begin
      w_sel_rate = '0;
      w_sel_up   = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (laneQualified[i]) begin
            w_sel_rate = w_lane_rate[i];
            w_sel_up   = w_lane_up[i];
         end
      end
   end

   // Next-state: abort over start over run outcome; success wins a same-cycle expiry
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else if (start) begin
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_RUN) begin
         if (w_success) begin
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
         end else if (w_expire) begin
            w_state_nxt = ST_TOUT;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Configuration latch; an abort in the same cycle suppresses the start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active  <= '0;
         r_exp_ts2 <= 1'b0;
         r_any     <= 1'b0;
         r_pad     <= 1'b0;
         r_link    <= '0;
         r_target  <= '0;
         r_timeout <= '0;
      end else if (start && !abort) begin
         r_active  <= activeLanes;
         r_exp_ts2 <= expectTs2;
         r_any     <= anyLaneMode;
         r_pad     <= padAllowed;
         r_link    <= expLinkNum;
         r_target  <= (target == '0) ? CNT_W'(1) : target;
         r_timeout <= timeoutCycles;
      end
   end

   // Run timer: cleared on start/abort, advances every RUN cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmr <= '0;
      end else if (w_clr) begin
         r_tmr <= '0;
      end else if (w_run) begin
         r_tmr <= r_tmr + TMR_W'(1);
      end
   end

   // Result capture: frozen from success until the next start or abort
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rate  <= '0;
         r_upcfg <= 1'b0;
      end else if (w_clr) begin
         r_rate  <= '0;
         r_upcfg <= 1'b0;
      end else if (w_load) begin
         r_rate  <= w_sel_rate;
         r_upcfg <= w_sel_up;
      end
   end

   assign busy     = (r_state == ST_RUN);
   assign done     = (r_state == ST_DONE);
   assign timedOut = (r_state == ST_TOUT);
   assign rateId   = r_rate;
   assign upConfig = r_upcfg;

endmodule

// File: tb/tb_rx_os_consensus.sv
// Scoreboarded bench: each run's outcome is predicted from the lane-counting rules and checked by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_os_consensus;

   localparam int NL   = 16;
   localparam int CW   = 5;
   localparam int TW   = 24;
   localparam int SW   = 24;
   localparam int MAXC = 160;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [NL*SW-1:0] osSummary;
   logic [NL-1:0]    osValid;
   logic [NL-1:0]    activeLanes;
   logic             expectTs2;
   logic             anyLaneMode;
   logic             padAllowed;
   logic [7:0]       expLinkNum;
   logic [CW-1:0]    target;
   logic [TW-1:0]    timeoutCycles;
   logic             busy;
   logic             done;
   logic             timedOut;
   logic [NL-1:0]    laneQualified;
   logic [7:0]       rateId;
   logic             upConfig;

   always #5 clk = ~clk;

   rx_os_consensus #(.NUM_LANES(NL), .CNT_W(CW), .TMR_W(TW), .SUM_W(SW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .osSummary     (osSummary),
      .osValid       (osValid),
      .activeLanes   (activeLanes),
      .expectTs2     (expectTs2),
      .anyLaneMode   (anyLaneMode),
      .padAllowed    (padAllowed),
      .expLinkNum    (expLinkNum),
      .target        (target),
      .timeoutCycles (timeoutCycles),
      .busy          (busy),
      .done          (done),
      .timedOut      (timedOut),
      .laneQualified (laneQualified),
      .rateId        (rateId),
      .upConfig      (upConfig)
   );

   typedef struct {
      bit            tout;
      int            len;
      logic [NL-1:0] lq;
      logic [7:0]    rate;
      bit            up;
   } exp_t;

   exp_t        sb_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          b_vld [MAXC][NL];
   logic [23:0] b_sum [MAXC][NL];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [23:0] mk_sum(input logic [7:0] lk, input logic [7:0] rt,
                                          input bit ts2, input bit up);
      return {5'b0, up, ts2, ~ts2, rt, lk};
   endfunction

   task automatic fill_clear();
      for (int c = 0; c < MAXC; c++)
         for (int l = 0; l < NL; l++) begin
            b_vld[c][l] = 1'b0;
            b_sum[c][l] = '0;
         end
   endtask

   task automatic fill_lane(input int l, input int from, input int to, input logic [7:0] lk,
                            input logic [7:0] rt, input bit ts2, input bit up);
      for (int c = from; c <= to && c < MAXC; c++) begin
         b_vld[c][l] = 1'b1;
         b_sum[c][l] = mk_sum(lk, rt, ts2, up);
      end
   endtask

   // Mostly-good traffic per lane with occasional wrong type, wrong link, PAD link or content change
   task automatic gen_random(input logic [7:0] lk, input bit ts2);
      logic [7:0] lrate [NL];
      bit         lup   [NL];
      int         r;
      for (int l = 0; l < NL; l++) begin
         lrate[l] = 8'($urandom);
         lup[l]   = 1'($urandom);
      end
      for (int c = 0; c < MAXC; c++)
         for (int l = 0; l < NL; l++) begin
            b_vld[c][l] = ($urandom % 4) != 0;
            r = $urandom % 20;
            if (r == 0)      b_sum[c][l] = mk_sum(lk, lrate[l], ~ts2, lup[l]);
            else if (r == 1) b_sum[c][l] = mk_sum(lk + 8'd1, lrate[l], ts2, lup[l]);
            else if (r == 2) b_sum[c][l] = mk_sum(8'hF7, lrate[l], ts2, lup[l]);
            else begin
               if (r == 3) lrate[l] = 8'($urandom);
               b_sum[c][l] = mk_sum(lk, lrate[l], ts2, lup[l]);
            end
         end
   endtask

   // Reference: walk the beat table cycle by cycle. Success in RUN cycle j looks at the lane set
   // qualified by the counts after beat j-2; results reflect lane state after beat j-1.
   task automatic model(input logic [NL-1:0] mask, input bit ts2, input bit any, input bit pad,
                        input logic [7:0] lk, input int tgt_in, input int tmo, output exp_t e);
      int            cnt [NL];
      logic [7:0]    rt  [NL];
      bit            up  [NL];
      logic [NL-1:0] qh  [MAXC];
      logic [7:0]    rh  [MAXC][NL];
      bit            uh  [MAXC][NL];
      int            tgt;
      logic [NL-1:0] qprev;
      bit            succ, found, ok_t, ok_l;
      logic [23:0]   s;
      tgt = (tgt_in == 0) ? 1 : tgt_in;
      for (int l = 0; l < NL; l++) begin
         cnt[l] = 0; rt[l] = '0; up[l] = 1'b0;
      end
      e.tout = 1'b1; e.len = -1; e.lq = '0; e.rate = '0; e.up = 1'b0;
      for (int j = 0; j < MAXC; j++) begin
         qprev = (j >= 2) ? qh[j-2] : '0;
         succ  = any ? (qprev != '0) : ((mask != '0) && (qprev == mask));
         if (succ) begin
            e.tout = 1'b0;
            e.len  = j + 1;
            e.lq   = qh[j-1];
            found  = 1'b0;
            for (int l = 0; l < NL; l++)
               if (qprev[l] && !found) begin
                  found  = 1'b1;
                  e.rate = rh[j-1][l];
                  e.up   = uh[j-1][l];
               end
            return;
         end
         if (tmo != 0 && j == tmo - 1) begin
            e.tout = 1'b1;
            e.len  = j + 1;
            e.lq   = (j >= 1) ? qh[j-1] : '0;
            return;
         end
         for (int l = 0; l < NL; l++) begin
            if (!mask[l]) cnt[l] = 0;
            else if (b_vld[j][l]) begin
               s    = b_sum[j][l];
               ok_t = ts2 ? s[17] : s[16];
               ok_l = (s[7:0] == lk) || (pad && s[7:0] == 8'hF7);
               if (ok_t && ok_l) begin
                  if (s[15:8] == rt[l] && s[18] == up[l]) cnt[l] = (cnt[l] >= 31) ? 31 : cnt[l] + 1;
                  else begin
                     cnt[l] = 1; rt[l] = s[15:8]; up[l] = s[18];
                  end
               end else cnt[l] = 0;
            end
            qh[j][l] = mask[l] && (cnt[l] >= tgt);
            rh[j][l] = rt[l];
            uh[j][l] = up[l];
         end
      end
   endtask

   // Issue a start, then play the beat table. stop_at < 0 runs to the predicted end and
   // queues the prediction; otherwise only stop_at beats are played and nothing is queued.
   task automatic run_case(input logic [NL-1:0] mask, input bit ts2, input bit any, input bit pad,
                           input logic [7:0] lk, input int tgt, input int tmo, input int stop_at);
      exp_t e;
      int   ncyc;
      model(mask, ts2, any, pad, lk, tgt, tmo, e);
      if (stop_at >= 0) ncyc = stop_at;
      else if (e.len > 0) begin
         sb_q.push_back(e);
         ncyc = e.len;
      end else ncyc = MAXC;
      @(posedge clk); #1;
      activeLanes   = mask;
      expectTs2     = ts2;
      anyLaneMode   = any;
      padAllowed    = pad;
      expLinkNum    = lk;
      target        = CW'(tgt);
      timeoutCycles = TW'(tmo);
      start         = 1'b1;
      @(posedge clk); #1;
      start         = 1'b0;
      // Inputs are only meaningful at start; scramble them for the rest of the run
      activeLanes   = NL'($urandom);
      expectTs2     = ~ts2;
      anyLaneMode   = ~any;
      padAllowed    = ~pad;
      expLinkNum    = ~lk;
      target        = CW'($urandom);
      timeoutCycles = TW'($urandom_range(1, 5));
      for (int j = 0; j < ncyc; j++) begin
         for (int l = 0; l < NL; l++) begin
            osValid[l]           = b_vld[j][l];
            osSummary[l*SW +: SW] = b_sum[j][l];
         end
         @(posedge clk); #1;
      end
      osValid = '0;
      if (stop_at < 0) repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_tout"}, timedOut, 0);
      check({tag, "_laneq"}, laneQualified, 0);
      check({tag, "_rate"}, rateId, 0);
      check({tag, "_upcfg"}, upConfig, 0);
   endtask

   // Monitor: count RUN cycles; on each run completion pop the prediction and compare
   initial begin
      exp_t e;
      int   run_len   = 0;
      bit   prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
         end else begin
            if (busy) run_len++;
            if (prev_busy && !busy && (done || timedOut)) begin
               if (sb_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_end: done=%0b timedOut=%0b with no run outstanding", done, timedOut);
               end else begin
                  e = sb_q.pop_front();
                  check("end_timedout", timedOut, e.tout);
                  check("end_done", done, !e.tout);
                  check("run_len", run_len, e.len);
                  check("lane_qualified", laneQualified, e.lq);
                  check("rate_id", rateId, e.rate);
                  check("upconfig", upConfig, e.up);
               end
            end
            prev_busy = busy;
            if (start) run_len = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NL-1:0] m;
      bit            t2;
      logic [7:0]    lk;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      osSummary = '0; osValid = '0; activeLanes = '0;
      expectTs2 = 1'b0; anyLaneMode = 1'b0; padAllowed = 1'b0;
      expLinkNum = '0; target = '0; timeoutCycles = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b1;

      // All mode, 4 lanes, TS1, target 8, identical traffic
      fill_clear();
      for (int l = 0; l < 4; l++) fill_lane(l, 0, MAXC-1, 8'd5, 8'h2A, 1'b0, 1'b1);
      run_case(16'h000F, 0, 0, 0, 8'd5, 8, 150, -1);

      // Lane 2 breaks with a TS2 at beat 5; lane 1 changes rate id from beat 4
      b_sum[5][2] = mk_sum(8'd5, 8'h2A, 1'b1, 1'b1);
      fill_lane(1, 4, MAXC-1, 8'd5, 8'h33, 1'b0, 1'b1);
      run_case(16'h000F, 0, 0, 0, 8'd5, 8, 150, -1);

      // Any mode: lane 3 alone sends 16 good TS2s, lanes 0..2 carry a wrong link number
      fill_clear();
      for (int l = 0; l < 3; l++) fill_lane(l, 0, MAXC-1, 8'd6, 8'h11, 1'b1, 1'b1);
      fill_lane(3, 0, 15, 8'd5, 8'h55, 1'b1, 1'b0);
      run_case(16'h000F, 1, 1, 0, 8'd5, 16, 150, -1);

      // PAD link accepted only when allowed
      fill_clear();
      fill_lane(0, 0, MAXC-1, 8'hF7, 8'h4C, 1'b0, 1'b1);
      run_case(16'h0001, 0, 0, 1, 8'd9, 2, 150, -1);
      run_case(16'h0001, 0, 0, 0, 8'd9, 2, 100, -1);

      // Qualifying beat lands so that success coincides with the timer's last cycle
      fill_clear();
      fill_lane(0, 7, 7, 8'd3, 8'h77, 1'b0, 1'b1);
      run_case(16'h0001, 0, 0, 0, 8'd3, 1, 10, -1);

      // Target 0 behaves as 1
      fill_clear();
      fill_lane(0, 0, 0, 8'd3, 8'h19, 1'b0, 1'b0);
      run_case(16'h0001, 0, 0, 0, 8'd3, 0, 50, -1);

      // Empty mask in all mode can only time out
      fill_clear();
      for (int l = 0; l < NL; l++) fill_lane(l, 0, MAXC-1, 8'd3, 8'h19, 1'b0, 1'b0);
      run_case(16'h0000, 0, 0, 0, 8'd3, 1, 40, -1);

      // Abort mid-run with three lanes qualified
      fill_clear();
      for (int l = 0; l < 3; l++) fill_lane(l, 0, MAXC-1, 8'd5, 8'h11, 1'b0, 1'b0);
      run_case(16'h000F, 0, 0, 0, 8'd5, 2, 150, 8);
      check("pre_abort_laneq", laneQualified, 16'h0007);
      check("pre_abort_busy", busy, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_idle_outputs("abort");

      // Reset asserted mid-run clears outputs immediately
      run_case(16'h000F, 0, 0, 0, 8'd5, 2, 150, 8);
      check("pre_reset_laneq", laneQualified, 16'h0007);
      reset = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Restart while running with a narrower mask
      fill_clear();
      for (int l = 0; l < 4; l++) fill_lane(l, 0, MAXC-1, 8'd5, 8'h22, 1'b0, 1'b0);
      run_case(16'h000F, 0, 0, 0, 8'd5, 20, 150, 6);
      run_case(16'h0003, 0, 0, 0, 8'd5, 4, 150, -1);

      // Randomized runs
      for (int it = 0; it < 24; it++) begin
         t2 = 1'($urandom);
         lk = 8'($urandom);
         if ($urandom % 8 == 0) m = '0;
         else m = NL'($urandom) & NL'((32'd1 << $urandom_range(1, NL)) - 1);
         gen_random(lk, t2);
         run_case(m, t2, 1'($urandom), 1'($urandom), lk, $urandom_range(0, 6),
                  $urandom_range(20, 140), -1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
